flatten_feeder: RTL

- Producer side of the final-layer interface.
- Collects the flattened 14x14 binary feature map from layer 2 as a stream of IN_W-bit beats and packs it into an NUM_INPUTS-bit vector.
- Sequences the final layer through its clear/load cycle: drives its data, enable and clear lines, and waits for its done flag.
- Returns the class index to the system over a valid/ready result handshake.

---
 rtl/bnn_pkg.sv | 22 ++
 rtl/flatten_feeder.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/bnn_pkg.sv
// ---------------------------------------------------------------------------
// bnn_pkg
// Shared constants and types for the BNN final-layer interface.
//   NUM_INPUTS     : width of the flattened 14x14 binary feature map
//   NUM_CLASSES    : number of output classes of the final layer
//   CLASS_W        : width of a class index
//   feeder_state_t : sequencing states of flatten_feeder
// ---------------------------------------------------------------------------
package bnn_pkg;

    localparam int NUM_INPUTS  = 196;
    localparam int NUM_CLASSES = 10;
    localparam int CLASS_W     = 4;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        CLEAR  = 2'd1,
        ISSUE  = 2'd2,
        RESULT = 2'd3
    } feeder_state_t;

endpackage

// File: rtl/flatten_feeder.sv
// ---------------------------------------------------------------------------
// flatten_feeder
// Producer side of the final-layer interface. Packs IN_W-bit beats of the
// flattened feature map into an NUM_INPUTS-bit vector, runs the final layer
// through one clear/load cycle, and returns its class index over a
// valid/ready result handshake.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; a producer holding valid keeps its payload stable until that
// edge; ready may be withdrawn at any time.
//
// Ports
//   clock, reset      : clock and asynchronous active-low reset
//   flush             : synchronous abort back to FILL (ds_data kept)
//   in_valid/in_ready : beat handshake from layer 2, payload in_data
//   ds_data           : packed vector to the final layer
//   ds_en             : load enable to the final layer
//   ds_clear_n        : active-low clear pulse to the final layer
//   ds_answer/ds_done : class index and done flag from the final layer
//   result            : captured class index (0 on timeout)
//   result_err        : result produced by timeout
//   result_valid/result_ready : result handshake to the system
//   dbg_state         : current sequencing state
// ---------------------------------------------------------------------------
module flatten_feeder
    import bnn_pkg::*;
#(
    parameter int NUM_INPUTS = bnn_pkg::NUM_INPUTS,
    parameter int IN_W       = 14,
    parameter int TIMEOUT    = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_W-1:0]       in_data,
    output logic [NUM_INPUTS-1:0] ds_data,
    output logic                  ds_en,
    output logic                  ds_clear_n,
    input  logic [CLASS_W-1:0]    ds_answer,
    input  logic                  ds_done,
    output logic [CLASS_W-1:0]    result,
    output logic                  result_err,
    output logic                  result_valid,
    input  logic                  result_ready,
    output feeder_state_t         dbg_state
);

    localparam int NB  = NUM_INPUTS / IN_W;
    localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [BCW-1:0] LAST_BEAT = BCW'(NB - 1);
    localparam logic [7:0]     TMO_LIMIT = 8'(TIMEOUT);

    feeder_state_t         state_q;
    logic [BCW-1:0]        beat_cnt_q;
    logic [NUM_INPUTS-1:0] ds_data_q;
    logic                  ds_en_q;
    logic                  ds_clear_n_q;
    logic [CLASS_W-1:0]    result_q;
    logic                  result_err_q;
    logic                  result_valid_q;
    logic [7:0]            tmo_cnt_q;
    logic [7:0]            tmo_cnt_d;
    logic                  accept;

    // A beat offered alongside flush is refused rather than silently dropped
    // after acceptance, so the upstream keeps it.
    assign in_ready  = (state_q == FILL) && !flush;
    assign accept    = in_valid && in_ready;
    assign tmo_cnt_d = tmo_cnt_q + 8'd1;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= FILL;
            beat_cnt_q     <= '0;
            ds_data_q      <= '0;
            ds_en_q        <= 1'b0;
            ds_clear_n_q   <= 1'b1;
            result_q       <= '0;
            result_err_q   <= 1'b0;
            result_valid_q <= 1'b0;
            tmo_cnt_q      <= '0;
        end else if (flush) begin
            state_q        <= FILL;
            beat_cnt_q     <= '0;
            ds_en_q        <= 1'b0;
            ds_clear_n_q   <= 1'b1;
            result_valid_q <= 1'b0;
            tmo_cnt_q      <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (accept) begin
                        ds_data_q[beat_cnt_q*IN_W +: IN_W] <= in_data;
                        if (beat_cnt_q == LAST_BEAT) begin
                            beat_cnt_q   <= '0;
                            ds_clear_n_q <= 1'b0;
                            state_q      <= CLEAR;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    ds_clear_n_q <= 1'b1;
                    ds_en_q      <= 1'b1;
                    state_q      <= ISSUE;
                end
                ISSUE: begin
                    tmo_cnt_q <= tmo_cnt_d;
                    // The first ISSUE cycle (counter still 0) sees a done flag
                    // from registers that were only just cleared, so skip it.
                    if ((tmo_cnt_q != 8'd0) && ds_done) begin
                        result_q       <= ds_answer;
                        result_err_q   <= 1'b0;
                        result_valid_q <= 1'b1;
                        ds_en_q        <= 1'b0;
                        state_q        <= RESULT;
                    end else if (tmo_cnt_d == TMO_LIMIT) begin
                        result_q       <= '0;
                        result_err_q   <= 1'b1;
                        result_valid_q <= 1'b1;
                        ds_en_q        <= 1'b0;
                        state_q        <= RESULT;
                    end
                end
                RESULT: begin
                    if (result_ready) begin
                        result_valid_q <= 1'b0;
                        tmo_cnt_q      <= '0;
                        state_q        <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

    assign ds_data      = ds_data_q;
    assign ds_en        = ds_en_q;
    assign ds_clear_n   = ds_clear_n_q;
    assign result       = result_q;
    assign result_err   = result_err_q;
    assign result_valid = result_valid_q;
    assign dbg_state    = state_q;

endmodule
